// File: rtl/noc_flit_pkg.sv
// Shared flit layout and sink FSM encoding for the nearest-neighbour NoC endpoints.
package noc_flit_pkg;

  localparam int FLIT_W      = 20;
  localparam int PAYLOAD_W   = 16;
  localparam int PAYLOAD_MSB = 19;
  localparam int PAYLOAD_LSB = 4;
  localparam int CLUSTER_MSB = 3;
  localparam int CLUSTER_LSB = 2;
  localparam int LOCAL_MSB   = 1;
  localparam int LOCAL_LSB   = 0;

  typedef struct packed {
    logic [PAYLOAD_W-1:0] payload;
    logic [1:0]           dest_cluster;
    logic [1:0]           dest_local;
  } flit_t;

  typedef enum logic [1:0] {
    SINK_IDLE = 2'd0,
    SINK_RECV = 2'd1,
    SINK_DONE = 2'd2
  } sink_state_e;

endpackage

// File: rtl/sync_fifo_ptr.sv
// Single-clock FIFO with occupancy-based full/empty and a 1-cycle registered read port.
module sync_fifo_ptr #(
  parameter int DEPTH = 32,
  parameter int W     = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         rd_valid,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   occ_q, occ_d;
  logic [W-1:0]  rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;
  logic          do_pop;

  assign empty    = (occ_q == '0);
  assign full     = (occ_q == (AW+1)'(DEPTH));
  assign do_pop   = rd_en && !empty;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

  // wr_en is pre-qualified by the caller: it is only high when there is room or a pop this cycle.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = do_pop;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      rd_data_d = mem[rd_ptr_q];
    end
    case ({wr_en, do_pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

endmodule

// File: rtl/datain_sink_buf.sv
// Receive-side sink: captures ejected flits into a FIFO, counts them and flags a finished burst.
// Define DATAIN_SINK_CHECK_EN to build the destination and payload-sequence checkers.
module datain_sink_buf
  import noc_flit_pkg::*;
#(
  parameter int          DEPTH         = 32,
  parameter int          EXP_COUNT     = 30,
  parameter logic [1:0]  NODE_CLUSTER  = 2'd0,
  parameter logic [1:0]  NODE_LOCAL    = 2'd1,
  parameter logic [15:0] FIRST_PAYLOAD = 16'h0001
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              in_valid,
  input  logic [FLIT_W-1:0] datain,
  input  logic              rd_en,
  output logic [FLIT_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic              full,
  output logic [5:0]        rx_count,
  output logic              done,
  output logic              overflow,
  output logic              dest_err,
  output logic              seq_err
);

  sink_state_e state_q;
  logic        done_q;
  logic [5:0]  rx_count_q, rx_count_d;
  logic        overflow_q, overflow_d;
  logic        accept, drop, pop, last_flit;

  assign pop       = rd_en && !empty;
  assign last_flit = accept && (rx_count_q == 6'(EXP_COUNT - 1));

  // A full FIFO still takes a flit when a pop frees the slot in the same cycle.
  always_comb begin
    accept = 1'b0;
    drop   = 1'b0;
    if (state_q == SINK_RECV && enable && in_valid) begin
      if (!full || pop) accept = 1'b1;
      else              drop   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= SINK_IDLE;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        SINK_IDLE: if (enable) state_q <= SINK_RECV;
        SINK_RECV: begin
          if (last_flit) begin
            state_q <= SINK_DONE;
            done_q  <= 1'b1;
          end else if (!enable) begin
            state_q <= SINK_IDLE;
          end
        end
        SINK_DONE: state_q <= SINK_DONE;
        default:   state_q <= SINK_IDLE;
      endcase
    end
  end

  always_comb begin
    rx_count_d = rx_count_q;
    overflow_d = overflow_q | drop;
    if (accept && rx_count_q != 6'h3F) rx_count_d = rx_count_q + 6'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_count_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      rx_count_q <= rx_count_d;
      overflow_q <= overflow_d;
    end
  end

  assign rx_count = rx_count_q;
  assign done     = done_q;
  assign overflow = overflow_q;

`ifdef DATAIN_SINK_CHECK_EN
  flit_t       flit;
  logic [15:0] exp_q, exp_d;
  logic        dest_err_q, dest_err_d;
  logic        seq_err_q, seq_err_d;

  assign flit = flit_t'(datain);

  // The expected payload resyncs to each accepted flit, so a single gap flags only once.
  always_comb begin
    exp_d      = exp_q;
    dest_err_d = dest_err_q;
    seq_err_d  = seq_err_q;
    if (accept) begin
      if (flit.dest_cluster != NODE_CLUSTER || flit.dest_local != NODE_LOCAL) dest_err_d = 1'b1;
      if (flit.payload != exp_q) seq_err_d = 1'b1;
      exp_d = flit.payload + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q      <= FIRST_PAYLOAD;
      dest_err_q <= 1'b0;
      seq_err_q  <= 1'b0;
    end else begin
      exp_q      <= exp_d;
      dest_err_q <= dest_err_d;
      seq_err_q  <= seq_err_d;
    end
  end

  assign dest_err = dest_err_q;
  assign seq_err  = seq_err_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{NODE_CLUSTER, NODE_LOCAL, FIRST_PAYLOAD};
  assign dest_err   = 1'b0;
  assign seq_err    = 1'b0;
`endif

  sync_fifo_ptr #(
    .DEPTH (DEPTH),
    .W     (FLIT_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst),
    .wr_en    (accept),
    .wr_data  (datain),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .empty    (empty),
    .full     (full)
  );

endmodule

// File: tb/tb_datain_sink_buf.sv
// Directed bench for datain_sink_buf; a second instance with a longer burst exercises full/overflow.
module tb_datain_sink_buf;

  logic        clk = 1'b0;
  logic        rst, enable, in_valid, rd_en;
  logic [19:0] datain;

  logic [19:0] rd_data, rd_data_b;
  logic        rd_valid, empty, full, done, overflow, dest_err, seq_err;
  logic        rd_valid_b, empty_b, full_b, done_b, overflow_b, dest_err_b, seq_err_b;
  logic [5:0]  rx_count, rx_count_b;

  int vec_cnt = 0;
  int miscmp  = 0;

`ifdef DATAIN_SINK_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  always #5 clk = ~clk;

  datain_sink_buf u_dut (
    .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .datain(datain), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty), .full(full), .rx_count(rx_count),
    .done(done), .overflow(overflow), .dest_err(dest_err), .seq_err(seq_err)
  );

  datain_sink_buf #(.EXP_COUNT(40)) u_dut_b (
    .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .datain(datain), .rd_en(rd_en),
    .rd_data(rd_data_b), .rd_valid(rd_valid_b), .empty(empty_b), .full(full_b), .rx_count(rx_count_b),
    .done(done_b), .overflow(overflow_b), .dest_err(dest_err_b), .seq_err(seq_err_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscmp++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b0; enable = 1'b0; in_valid = 1'b0; rd_en = 1'b0; datain = '0;
    tick; tick;
    rst = 1'b1;
    tick;
  endtask

  task automatic arm;
    enable = 1'b1;
    tick;
  endtask

  task automatic push(input logic [19:0] f);
    in_valid = 1'b1; datain = f;
    tick;
    in_valid = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [19:0] exp);
    rd_en = 1'b1;
    tick;
    rd_en = 1'b0;
    check({tag, "_vld"}, rd_valid, 1);
    check(tag, rd_data, exp);
  endtask

  function automatic logic [19:0] fl(input int p);
    return {p[15:0], 4'h1};
  endfunction

  initial begin
    // reset state, held low across edges
    rst = 1'b0; enable = 1'b0; in_valid = 1'b0; rd_en = 1'b0; datain = '0;
    tick; tick;
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_rx_count", rx_count, 0);
    check("rst_done", done, 0);
    check("rst_overflow", overflow, 0);
    check("rst_dest_err", dest_err, 0);
    check("rst_seq_err", seq_err, 0);

    // full 30-flit burst, then drain
    do_reset; arm;
    for (int i = 1; i <= 30; i++) begin
      push(fl(i));
      if (i == 29) check("burst_done_early", done, 0);
    end
    check("burst_done", done, 1);
    check("burst_rx_count", rx_count, 30);
    check("burst_full", full, 0);
    for (int i = 1; i <= 30; i++) pop_chk($sformatf("burst_rd%0d", i), fl(i));
    check("burst_empty", empty, 1);
    rd_en = 1'b1; tick; rd_en = 1'b0;
    check("burst_rd_when_empty", rd_valid, 0);
    check("burst_overflow", overflow, 0);
    check("burst_dest_err", dest_err, 0);
    check("burst_seq_err", seq_err, 0);

    // sequence gap flags once, data intact
    do_reset; arm;
    push(20'h00011); push(20'h00021);
    check("seq_ok2", seq_err, 0);
    push(20'h00041);
    check("seq_gap", seq_err, CHK);
    push(20'h00051);
    check("seq_after", seq_err, CHK);
    check("seq_rx_count", rx_count, 4);
    check("seq_dest_err", dest_err, 0);
    pop_chk("seq_rd1", 20'h00011);
    pop_chk("seq_rd2", 20'h00021);
    pop_chk("seq_rd3", 20'h00041);
    pop_chk("seq_rd4", 20'h00051);

    // wrong destination is flagged but still stored
    do_reset; arm;
    push(20'h00012);
    check("dest_err", dest_err, CHK);
    check("dest_seq_err", seq_err, 0);
    check("dest_rx_count", rx_count, 1);
    check("dest_empty", empty, 0);
    pop_chk("dest_rd", 20'h00012);

    // fill to full, push with pop, then overflow
    do_reset; arm;
    for (int i = 1; i <= 32; i++) push(fl(i));
    check("ovf_full", full_b, 1);
    check("ovf_pre_overflow", overflow_b, 0);
    check("ovf_rx_count", rx_count_b, 32);
    check("ovf_done_b", done_b, 0);
    check("ovf_a_done", done, 1);
    check("ovf_a_rx_count", rx_count, 30);
    rd_en = 1'b1; in_valid = 1'b1; datain = fl(33);
    tick;
    rd_en = 1'b0; in_valid = 1'b0;
    check("pp_full", full_b, 1);
    check("pp_overflow", overflow_b, 0);
    check("pp_rx_count", rx_count_b, 33);
    check("pp_rd_valid", rd_valid_b, 1);
    check("pp_rd_data", rd_data_b, fl(1));
    check("pp_a_rd_valid", rd_valid, 1);
    check("pp_a_rd_data", rd_data, fl(1));
    check("pp_a_rx_count", rx_count, 30);
    check("pp_a_overflow", overflow, 0);
    push(fl(34));
    check("ovf_overflow", overflow_b, 1);
    check("ovf_rx_hold", rx_count_b, 33);
    check("ovf_full_hold", full_b, 1);
    check("ovf_seq_err", seq_err_b, 0);

    // async reset mid-burst, then a full burst
    do_reset; arm;
    for (int i = 1; i <= 10; i++) push(fl(i));
    check("mid_rx_count", rx_count, 10);
    rst = 1'b0;
    #2;
    check("mid_rst_rx_count", rx_count, 0);
    check("mid_rst_empty", empty, 1);
    check("mid_rst_done", done, 0);
    enable = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    arm;
    for (int i = 1; i <= 30; i++) push(fl(i));
    check("mid_done", done, 1);
    check("mid_rx_final", rx_count, 30);
    check("mid_seq_err", seq_err, 0);

    // disabled receiver ignores flits; first enable cycle ignored; pause and resume
    do_reset;
    in_valid = 1'b1; datain = fl(1);
    tick; tick; tick;
    in_valid = 1'b0;
    check("idle_rx_count", rx_count, 0);
    check("idle_empty", empty, 1);
    enable = 1'b1; in_valid = 1'b1; datain = fl(1);
    tick;
    check("arm_cycle_ignored", rx_count, 0);
    tick;
    in_valid = 1'b0;
    check("arm_accept", rx_count, 1);
    enable = 1'b0; in_valid = 1'b1; datain = fl(2);
    tick; tick;
    in_valid = 1'b0;
    check("pause_rx_count", rx_count, 1);
    enable = 1'b1;
    tick;
    push(fl(2));
    check("resume_rx_count", rx_count, 2);
    check("resume_seq_err", seq_err, 0);
    pop_chk("resume_rd1", fl(1));
    pop_chk("resume_rd2", fl(2));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
    $finish;
  end

endmodule

// File: doc/datain_sink_buf.md
Name: datain_sink_buf

Overview:
- Receive-side endpoint for the nearest-neighbour traffic set; the counterpart of the per-node injection ROMs.
- Captures 20-bit flits ejected by the router local port into a FIFO.
- Counts flits, checks destination and payload sequence, and raises done after the expected burst.
- The testbench or host drains captured words through a read port.

Parameters:
- DEPTH, 32: FIFO depth in flits. Power of two.
- EXP_COUNT, 30: number of flits that completes a burst.
- NODE_CLUSTER, 2'd0: this node's cluster id.
- NODE_LOCAL, 2'd1: this node's local id.
- FIRST_PAYLOAD, 16'h0001: payload expected on the first flit.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- enable  in  1  arms the receiver; flits are ignored while low
- in_valid  in  1  flit strobe from the router eject port; no backpressure
- datain  in  20  flit: [19:4] payload, [3:2] dest_cluster, [1:0] dest_local
- rd_en  in  1  pop request
- rd_data  out  20  popped flit, registered
- rd_valid  out  1  rd_data valid pulse
- empty  out  1  FIFO empty
- full  out  1  FIFO full
- rx_count  out  6  accepted flits, saturating at 63
- done  out  1  sticky; EXP_COUNT flits accepted
- overflow  out  1  sticky; flit arrived while full
- dest_err  out  1  sticky; destination mismatch seen
- seq_err  out  1  sticky; payload out of sequence

Behaviour:
- Reset (rst low, asynchronous):
  - All outputs are 0, except empty=1.
  - Pointers are 0; FSM goes to IDLE; expected payload is loaded with FIRST_PAYLOAD.
- FSM states: IDLE, RECV, DONE.
  - IDLE -> RECV when enable=1, in the cycle after enable is sampled high.
  - RECV -> DONE on the cycle the EXP_COUNT-th flit is accepted.
  - DONE is terminal until reset. Flits are ignored and counters frozen; the read port stays operational.
  - RECV -> IDLE if enable drops. Counters and flags are held, and the burst resumes on re-enable.
- Accept rule: in RECV with in_valid=1, the flit is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - An accepted flit is written at wr_ptr, which increments modulo DEPTH.
  - rx_count increments and saturates at 63.
- Full with no simultaneous pop: the flit is dropped and overflow is set. rx_count does not increment.
- Dest check: on every accepted flit, dest_err is set if datain[3:2]!=NODE_CLUSTER or datain[1:0]!=NODE_LOCAL. The flit is still stored.
- Sequence check: on every accepted flit, seq_err is set if payload!=exp.
  - exp then becomes payload+1 (16-bit wrap), so the check resyncs and one gap flags once.
- Read: if rd_en=1 and not empty, rd_data<=mem[rd_ptr] and rd_valid=1 the next cycle; rd_ptr increments.
  - rd_en while empty has no effect and rd_valid=0.
  - Read latency is 1 cycle.
- Simultaneous push and pop: occupancy is unchanged.
  - With the FIFO empty, the pop is ignored; the write occurs and empty deasserts the next cycle.
- full and empty are derived from an occupancy counter of width clog2(DEPTH)+1.
- done asserts in the cycle after the final accept.

Optional Feature:
- DATAIN_SINK_CHECK_EN
  - Defined: dest_err and seq_err logic and the expected-payload register are present, as above.
  - Undefined: dest_err and seq_err are tied 0 and no check logic is synthesised. Capture, counting and done are unchanged.

Decomposition:
- Shared package noc_flit_pkg holds:
  - FLIT_W=20 and the payload/dest field slice constants.
  - The flit typedef with payload, dest_cluster and dest_local fields.
  - The sink FSM state enum.
- One natural sub-module: sync_fifo_ptr. It holds the storage array, pointers, occupancy, full/empty and the 1-cycle registered read.
- FSM, counters and checkers stay in the top level.

Test Plan:
- Reset then enable. Inject 30 flits 0x00011..0x001E1, one per cycle, then pop all 30.
  -> done=1 one cycle after the 30th flit; rx_count=30; rd_data sequence 0x00011..0x001E1; all error flags 0; empty=1 at end.
- Inject 0x00011, 0x00021, 0x00041.
  -> seq_err sets after the third flit. Then inject 0x00051 -> no further change, and the stored data is intact.
- Inject 0x00012 (dest_local=2).
  -> dest_err=1; the flit is still stored; rx_count=1.
- Inject 33 flits with no reads.
  -> full after 32; overflow=1; rx_count=32.
- Inject with a simultaneous pop on the full FIFO.
  -> flit accepted; overflow stays 0; full stays 1.
- Assert rst low mid-burst after 10 flits.
  -> outputs clear immediately, empty=1; re-enable and a full 30-flit burst completes with done=1.
- enable=0 while in_valid pulses with 0x00011.
  -> nothing captured; rx_count=0; FSM stays in IDLE.
